// File: rtl/klein_pkg.sv
// Shared KLEIN-80 definitions: sizes, key type, key-schedule FSM states and the 4-bit S-box.
package klein_pkg;

    localparam int KLEIN_NR    = 16;
    localparam int KLEIN_KEY_W = 80;
    localparam int KLEIN_RC_W  = 8;

    typedef logic [KLEIN_KEY_W-1:0] klein_key_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ksc_state_e;

    function automatic logic [3:0] klein_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;
            4'h1: y = 4'h4;
            4'h2: y = 4'hA;
            4'h3: y = 4'h9;
            4'h4: y = 4'h1;
            4'h5: y = 4'hF;
            4'h6: y = 4'hB;
            4'h7: y = 4'h0;
            4'h8: y = 4'hC;
            4'h9: y = 4'h3;
            4'hA: y = 4'h2;
            4'hB: y = 4'h6;
            4'hC: y = 4'h8;
            4'hD: y = 4'hE;
            4'hE: y = 4'hD;
            default: y = 4'h5;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/key_gen.sv
// One KLEIN-80 key-schedule step: byte-rotate both halves, Feistel swap, round constant
// into byte 3 of the new left half, S-box on bytes 2 and 3 of the new right half.
module key_gen
    import klein_pkg::*;
(
    input  klein_key_t              key,
    input  logic [KLEIN_RC_W-1:0]   rc,
    output klein_key_t              key_next
);

    logic [39:0] a_rot;
    logic [39:0] b_rot;
    logic [39:0] a_new;
    logic [39:0] b_new;

    always_comb begin
        a_rot = {key[71:40], key[79:72]};
        b_rot = {key[31:0],  key[39:32]};
        a_new = b_rot;
        b_new = a_rot ^ b_rot;
        a_new[23:16] = a_new[23:16] ^ rc;
        b_new[31:16] = {klein_sbox(b_new[31:28]), klein_sbox(b_new[27:24]),
                        klein_sbox(b_new[23:20]), klein_sbox(b_new[19:16])};
        key_next = {a_new, b_new};
    end

endmodule

// File: rtl/klein_key_sched_ctrl.sv
// Iterative KLEIN-80 key-schedule sequencer: one shared key_gen step walks sk^1..sk^(NR+1),
// optionally streaming every round key over a valid/ready handshake.
module klein_key_sched_ctrl
    import klein_pkg::*;
#(
    parameter int NR    = KLEIN_NR,
    parameter int KEY_W = KLEIN_KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stream_en,
    input  logic [KEY_W-1:0] key_in,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_data,
    output logic [4:0]       rk_round,
    output logic             busy,
    output logic             done,
    output logic [KEY_W-1:0] final_key
);

    localparam logic [4:0] LAST_ROUND = 5'(NR + 1);

    ksc_state_e       state;
    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] key_nxt;
    logic [4:0]       round;
    logic             stream_q;
    logic             done_q;
    logic [KEY_W-1:0] final_q;
    logic             advance;

    key_gen u_key_gen (
        .key      (key_reg),
        .rc       ({3'b000, round}),
        .key_next (key_nxt)
    );

    // In RUN with streaming, rk_valid is already 1, so acceptance reduces to rk_ready.
    assign advance = stream_q ? rk_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_reg  <= '0;
            round    <= '0;
            stream_q <= 1'b0;
            done_q   <= 1'b0;
            final_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        key_reg  <= key_in;
                        round    <= 5'd1;
                        stream_q <= stream_en;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (advance) begin
                        if (round == LAST_ROUND) begin
                            final_q <= key_reg;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            key_reg <= key_nxt;
                            round   <= round + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign rk_valid  = (state == RUN) && stream_q;
    assign rk_data   = key_reg;
    assign rk_round  = round;
    assign done      = done_q;
    assign final_key = final_q;

endmodule

// File: tb/tb_klein_key_sched_ctrl.sv
// Directed bench for klein_key_sched_ctrl against an independent byte-level KLEIN-80 schedule model.
module tb_klein_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        stream_en;
    logic [79:0] key_in;
    logic        rk_valid;
    logic        rk_ready;
    logic [79:0] rk_data;
    logic [4:0]  rk_round;
    logic        busy;
    logic        done;
    logic [79:0] final_key;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [3:0] SB [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                                       4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};

    klein_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .stream_en (stream_en),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .busy      (busy),
        .done      (done),
        .final_key (final_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-array formulation; byte 0 is the most significant byte of the key.
    function automatic logic [79:0] ks_step(input logic [79:0] k, input int rc);
        logic [7:0]  b [10];
        logic [7:0]  n [10];
        logic [79:0] r;
        for (int i = 0; i < 10; i++) b[i] = k[79-8*i -: 8];
        for (int j = 0; j < 5; j++) begin
            n[j]   = b[5 + (j + 1) % 5];
            n[5+j] = b[(j + 1) % 5] ^ b[5 + (j + 1) % 5];
        end
        n[2] = n[2] ^ rc[7:0];
        n[6] = {SB[n[6][7:4]], SB[n[6][3:0]]};
        n[7] = {SB[n[7][7:4]], SB[n[7][3:0]]};
        r = '0;
        for (int i = 0; i < 10; i++) r[79-8*i -: 8] = n[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one schedule from the current (IDLE) cycle. stall_r/stall_n hold rk_ready low,
    // abort_r aborts together with that round's handshake, pulse_r pulses start mid-run.
    task automatic run_ks(input logic [79:0] k, input logic se, input int stall_r,
                          input int stall_n, input int abort_r, input int pulse_r,
                          input logic [79:0] prev_fk, output int cyc,
                          output logic [79:0] fk);
        logic [79:0] ek;
        int          er;
        int          stalls;
        bit          fin;
        ek = k; er = 1; stalls = stall_n; cyc = 0; fin = 0; fk = prev_fk;
        start = 1'b1; stream_en = se; key_in = k; rk_ready = se;
        tick();
        start = 1'b0; stream_en = ~se; key_in = ~k;
        while (!fin && cyc < 100) begin
            start = 1'b0;
            if (done) begin
                fin = 1;
                chk("final_key", final_key, ek);
                chk("done_busy", 80'(busy), 80'(0));
                chk("done_round", 80'(er), 80'(17));
                fk = ek;
            end else begin
                chk("busy", 80'(busy), 80'(1));
                chk("rk_round", 80'(rk_round), 80'(er));
                chk("rk_data", rk_data, ek);
                chk("rk_valid", 80'(rk_valid), 80'(se));
                if (se && er == abort_r) begin
                    rk_ready = 1'b1;
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk("abort_busy", 80'(busy), 80'(0));
                    chk("abort_valid", 80'(rk_valid), 80'(0));
                    chk("abort_done", 80'(done), 80'(0));
                    for (int i = 0; i < 3; i++) begin
                        tick();
                        chk("abort_no_beat", 80'(rk_valid), 80'(0));
                        chk("abort_no_done", 80'(done), 80'(0));
                    end
                    chk("abort_final_key", final_key, prev_fk);
                    cyc = -1;
                    return;
                end
                if (er == pulse_r) start = 1'b1;
                rk_ready = !(se && er == stall_r && stalls > 0);
                if (!rk_ready) stalls--;
                if ((!se || rk_ready) && er < 17) begin
                    ek = ks_step(ek, er);
                    er++;
                end
                tick();
                cyc++;
            end
        end
        if (!fin) chk("done_timeout", 80'(0), 80'(1));
        rk_ready = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [79:0] fk;
        logic [79:0] fk_prev;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stream_en = 1'b0;
        key_in = '0; rk_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_done", 80'(done), 80'(0));
        chk("rst_valid", 80'(rk_valid), 80'(0));
        chk("rst_round", 80'(rk_round), 80'(0));
        chk("rst_data", rk_data, 80'(0));
        chk("rst_final", final_key, 80'(0));
        rst_n = 1'b1;
        tick();

        // start together with abort in IDLE is blocked
        start = 1'b1; abort = 1'b1; key_in = 80'h1234;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_busy", 80'(busy), 80'(0));
        chk("idle_abort_round", 80'(rk_round), 80'(0));

        // no-stream, zero key, start pulsed mid-run
        run_ks(80'h0, 1'b0, 0, 0, 0, 3, 80'h0, cyc, fk);
        chk("nostream_latency", 80'(cyc), 80'(17));

        // back-to-back: stream run launched in the done cycle
        run_ks(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 0, 0, fk, cyc, fk);
        chk("stream_latency", 80'(cyc), 80'(17));

        // backpressure at round 4 for 5 cycles
        run_ks(80'h0123_4567_89AB_CDEF_1357, 1'b1, 4, 5, 0, 0, fk, cyc, fk);
        chk("stall_latency", 80'(cyc), 80'(22));
        fk_prev = fk;

        // abort at round 9 concurrent with a handshake
        run_ks(80'hA5A5_5A5A_0F0F_F0F0_3C3C, 1'b1, 0, 0, 9, 0, fk_prev, cyc, fk);
        chk("abort_taken", 80'(cyc), 80'(-1));

        // reset mid-run at round 5
        start = 1'b1; stream_en = 1'b0; key_in = 80'hDEAD_BEEF_0000_1111_2222;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset_round", 80'(rk_round), 80'(5));
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 80'(busy), 80'(0));
        chk("midrst_valid", 80'(rk_valid), 80'(0));
        chk("midrst_round", 80'(rk_round), 80'(0));
        chk("midrst_data", rk_data, 80'(0));
        chk("midrst_final", final_key, 80'(0));
        chk("midrst_done", 80'(done), 80'(0));
        tick();
        rst_n = 1'b1;
        tick();
        run_ks(80'h8000_0000_0000_0000_0001, 1'b1, 0, 0, 0, 0, 80'h0, cyc, fk);
        chk("post_reset_latency", 80'(cyc), 80'(17));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
